adc_power_seq: RTL and testbench

- Power-management sequencer that drives the power, retention and isolation controls of the ADC/output top-level (`rtl_top`).
  - These are the controls the bench currently toggles by hand.
- Shutdown sequence: drains the ADC, isolates it, saves retention state, then removes the ADC rails and output-domain power.
- Wake sequence: restores the selected rail, waits for the ramp, restores retention and releases isolation.
- Sits directly upstream of `rtl_top`'s `ADC_PWR_*` / `OUT_*` ports in the always-on domain.

---
 rtl/adc_pwr_pkg.sv | 29 ++
 rtl/pwr_dwell_cnt.sv | 25 ++
 rtl/adc_power_seq.sv | 131 +++++++++++++
 tb/tb_adc_power_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pwr_pkg.sv
// Shared state encoding and rail-level helpers for the ADC power sequencer.
package adc_pwr_pkg;

    typedef enum logic [3:0] {
        ACTIVE  = 4'd0,
        LVL_SW  = 4'd1,
        DRAIN   = 4'd2,
        ISOLATE = 4'd3,
        SAVE    = 4'd4,
        PWR_DN  = 4'd5,
        OFF     = 4'd6,
        PWR_UP  = 4'd7,
        RESTORE = 4'd8
    } pwr_state_e;

    localparam logic [1:0] LVL_LOW  = 2'd0;
    localparam logic [1:0] LVL_MOD  = 2'd1;
    localparam logic [1:0] LVL_HIGH = 2'd2;

    // {high, moderate, low}; code 3 aliases the low rail
    function automatic logic [2:0] rail_onehot(input logic [1:0] lvl);
        case (lvl)
            LVL_MOD:  return 3'b010;
            LVL_HIGH: return 3'b100;
            default:  return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/pwr_dwell_cnt.sv
// Loadable saturating down-counter timing each dwell state of the sequencer.
module pwr_dwell_cnt #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/adc_power_seq.sv
// Always-on sequencer driving ADC rail, isolation and retention controls
// through drain/isolate/save/power-down and power-up/restore sequences.
module adc_power_seq
    import adc_pwr_pkg::*;
#(
    parameter int SAVE_CYC    = 4,
    parameter int RAMP_CYC    = 8,
    parameter int RESTORE_CYC = 2,
    parameter int DRAIN_MAX   = 64,
    parameter int CW          = 8
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_shutdown_req,
    input  logic       i_wakeup_req,
    input  logic [1:0] i_level_sel,
    input  logic       i_adc_busy,
    output logic       o_ADC_PWR_low,
    output logic       o_ADC_PWR_moderate,
    output logic       o_ADC_PWR_high,
    output logic       o_OUT_PWR,
    output logic       o_OUT_RET,
    output logic       o_OUT_RET_PWR,
    output logic       o_iso_en,
    output logic [2:0] o_pwr_state,
    output logic       o_seq_done,
    output logic       o_drain_timeout
);

    pwr_state_e    r_state, w_nxt;
    logic [1:0]    r_lvl, w_lvl_nxt;
    logic [2:0]    r_rails;
    logic          r_out_pwr, r_out_ret, r_ret_pwr, r_iso, r_done, r_tout;
    logic          w_load, w_zero, w_tout_hit;
    logic [CW-1:0] w_load_val;

    // Counter preload so the state lasts exactly N cycles (exit when zero)
    function automatic logic [CW-1:0] dwell_len(input pwr_state_e s);
        case (s)
            LVL_SW, PWR_UP: return CW'(RAMP_CYC - 1);
            DRAIN:          return CW'(DRAIN_MAX - 1);
            SAVE:           return CW'(SAVE_CYC - 1);
            RESTORE:        return CW'(RESTORE_CYC - 1);
            default:        return '0;
        endcase
    endfunction

    pwr_dwell_cnt #(.CW(CW)) u_dwell (
        .i_clk      (i_clk),
        .i_clr      (i_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_nxt      = r_state;
        w_lvl_nxt  = r_lvl;
        w_tout_hit = 1'b0;
        case (r_state)
            ACTIVE: begin
                if (i_shutdown_req)
                    w_nxt = DRAIN;
                else if (rail_onehot(i_level_sel) != rail_onehot(r_lvl)) begin
                    w_nxt     = LVL_SW;
                    w_lvl_nxt = i_level_sel;
                end
            end
            LVL_SW:  if (w_zero) w_nxt = ACTIVE;
            DRAIN: begin
                if (!i_adc_busy)
                    w_nxt = ISOLATE;
                else if (w_zero) begin
                    w_nxt      = ISOLATE;
                    w_tout_hit = 1'b1;
                end
            end
            ISOLATE: w_nxt = SAVE;
            SAVE:    if (w_zero) w_nxt = PWR_DN;
            PWR_DN:  w_nxt = OFF;
            OFF: begin
                if (i_wakeup_req) begin
                    w_nxt     = PWR_UP;
                    w_lvl_nxt = i_level_sel;
                end
            end
            PWR_UP:  if (w_zero) w_nxt = RESTORE;
            RESTORE: if (w_zero) w_nxt = ACTIVE;
            default: w_nxt = ACTIVE;
        endcase
        w_load     = (w_nxt != r_state);
        w_load_val = dwell_len(w_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state   <= ACTIVE;
            r_lvl     <= LVL_LOW;
            r_rails   <= 3'b001;
            r_out_pwr <= 1'b1;
            r_out_ret <= 1'b0;
            r_ret_pwr <= 1'b1;
            r_iso     <= 1'b0;
            r_done    <= 1'b0;
            r_tout    <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_lvl     <= w_lvl_nxt;
            r_rails   <= (w_nxt inside {PWR_DN, OFF}) ? 3'b000 : rail_onehot(w_lvl_nxt);
            r_out_pwr <= !(w_nxt inside {PWR_DN, OFF});
            r_out_ret <= (w_nxt inside {SAVE, PWR_DN, OFF, PWR_UP});
            r_ret_pwr <= 1'b1;
            r_iso     <= !(w_nxt inside {ACTIVE, DRAIN});
            r_done    <= (w_nxt != r_state) && (w_nxt inside {ACTIVE, OFF});
            r_tout    <= r_tout | w_tout_hit;
        end
    end

    assign o_ADC_PWR_low      = r_rails[0];
    assign o_ADC_PWR_moderate = r_rails[1];
    assign o_ADC_PWR_high     = r_rails[2];
    assign o_OUT_PWR          = r_out_pwr;
    assign o_OUT_RET          = r_out_ret;
    assign o_OUT_RET_PWR      = r_ret_pwr;
    assign o_iso_en           = r_iso;
    // RESTORE has no 3-bit code of its own; it reports as the tail of PWR_UP
    assign o_pwr_state        = (r_state == RESTORE) ? 3'(PWR_UP) : r_state[2:0];
    assign o_seq_done         = r_done;
    assign o_drain_timeout    = r_tout;

endmodule

// File: tb/tb_adc_power_seq.sv
// Randomized bench: each operation is expanded into an expected per-cycle
// output timeline built from the sequence durations, then compared cycle by cycle.
module tb_adc_power_seq;

    localparam int SAVE_CYC    = 4;
    localparam int RAMP_CYC    = 8;
    localparam int RESTORE_CYC = 2;
    localparam int DRAIN_MAX   = 64;

    logic       clk = 1'b0;
    logic       clr, shutdown_req, wakeup_req, adc_busy;
    logic [1:0] level_sel;
    logic       pwr_low, pwr_mod, pwr_high, out_pwr, out_ret, out_ret_pwr, iso_en;
    logic [2:0] pwr_state;
    logic       seq_done, drain_timeout;

    int n_chk = 0;
    int n_err = 0;

    bit         m_on;
    logic [1:0] m_lvl;
    bit         m_tout;

    always #5 clk = ~clk;

    adc_power_seq dut (
        .i_clk              (clk),
        .i_clr              (clr),
        .i_shutdown_req     (shutdown_req),
        .i_wakeup_req       (wakeup_req),
        .i_level_sel        (level_sel),
        .i_adc_busy         (adc_busy),
        .o_ADC_PWR_low      (pwr_low),
        .o_ADC_PWR_moderate (pwr_mod),
        .o_ADC_PWR_high     (pwr_high),
        .o_OUT_PWR          (out_pwr),
        .o_OUT_RET          (out_ret),
        .o_OUT_RET_PWR      (out_ret_pwr),
        .o_iso_en           (iso_en),
        .o_pwr_state        (pwr_state),
        .o_seq_done         (seq_done),
        .o_drain_timeout    (drain_timeout)
    );

    wire [11:0] obs = {pwr_state, pwr_high, pwr_mod, pwr_low, out_pwr, out_ret,
                       out_ret_pwr, iso_en, seq_done, drain_timeout};

    function automatic logic [2:0] rail(input logic [1:0] l);
        return (l == 2'd1) ? 3'b010 : (l == 2'd2) ? 3'b100 : 3'b001;
    endfunction

    // {state, rails, OUT_PWR, OUT_RET, OUT_RET_PWR(always 1), iso, done, timeout}
    function automatic logic [11:0] snap(input logic [2:0] st, input logic [2:0] rl,
                                         input bit pwr, input bit ret, input bit iso,
                                         input bit done, input bit tout);
        return {st, rl, pwr, ret, 1'b1, iso, done, tout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input string tag, input logic [11:0] e);
        @(posedge clk);
        #1;
        chk(tag, {20'd0, obs}, {20'd0, e});
        chk("rails_onehot0", 32'($onehot0({pwr_high, pwr_mod, pwr_low})), 32'd1);
    endtask

    task automatic do_reset();
        clr = 1'b0; shutdown_req = 1'b0; wakeup_req = 1'b0;
        level_sel = 2'd0; adc_busy = 1'b0;
        m_on = 1'b1; m_lvl = 2'd0; m_tout = 1'b0;
        tick("reset", snap(3'd0, 3'b001, 1, 0, 0, 0, 0));
        clr = 1'b1;
    endtask

    // B = number of DRAIN cycles for which adc_busy is seen high
    task automatic do_shutdown(input int B, input bit both, input int abort_at);
        logic [11:0] q[$];
        logic [2:0]  rl;
        int          d;
        bit          to, t;
        rl = rail(m_lvl);
        d  = ((B < DRAIN_MAX - 1) ? B : DRAIN_MAX - 1) + 1;
        to = (B >= DRAIN_MAX);
        t  = m_tout | to;
        for (int i = 0; i < d; i++) q.push_back(snap(3'd2, rl, 1, 0, 0, 0, m_tout));
        q.push_back(snap(3'd3, rl, 1, 0, 1, 0, t));
        for (int i = 0; i < SAVE_CYC; i++) q.push_back(snap(3'd4, rl, 1, 1, 1, 0, t));
        q.push_back(snap(3'd5, 3'b000, 0, 1, 1, 0, t));
        q.push_back(snap(3'd6, 3'b000, 0, 1, 1, 1, t));
        shutdown_req = 1'b1; wakeup_req = both; adc_busy = (B > 0);
        level_sel = 2'($urandom % 4);
        for (int j = 0; j < q.size(); j++) begin
            if (j == abort_at) begin do_reset(); return; end
            tick("shutdown_seq", q[j]);
            wakeup_req = 1'b0;
            adc_busy   = (j < B);
            level_sel  = 2'($urandom % 4);
        end
        m_on = 1'b0; m_tout = t;
    endtask

    task automatic do_wakeup(input logic [1:0] L, input int abort_at);
        logic [11:0] q[$];
        for (int i = 0; i < RAMP_CYC; i++) q.push_back(snap(3'd7, rail(L), 1, 1, 1, 0, m_tout));
        for (int i = 0; i < RESTORE_CYC; i++) q.push_back(snap(3'd7, rail(L), 1, 0, 1, 0, m_tout));
        q.push_back(snap(3'd0, rail(L), 1, 0, 0, 1, m_tout));
        shutdown_req = 1'b0; wakeup_req = 1'b1; level_sel = L;
        adc_busy = 1'($urandom % 2);
        for (int j = 0; j < q.size(); j++) begin
            if (j == abort_at) begin do_reset(); return; end
            tick("wakeup_seq", q[j]);
            wakeup_req = 1'($urandom % 2);
            level_sel  = (j < q.size() - 1) ? 2'($urandom % 4) : L;
        end
        m_on = 1'b1; m_lvl = L;
    endtask

    task automatic do_lvlsw(input logic [1:0] L);
        logic [11:0] q[$];
        for (int i = 0; i < RAMP_CYC; i++) q.push_back(snap(3'd1, rail(L), 1, 0, 1, 0, m_tout));
        q.push_back(snap(3'd0, rail(L), 1, 0, 0, 1, m_tout));
        shutdown_req = 1'b0; level_sel = L;
        for (int j = 0; j < q.size(); j++) begin
            tick("level_switch", q[j]);
            level_sel = (j < q.size() - 1) ? 2'($urandom % 4) : L;
        end
        m_lvl = L;
    endtask

    // Steady-state cycles with inputs that must be ignored in the current state
    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            adc_busy = 1'($urandom % 2);
            if (m_on) begin
                shutdown_req = 1'b0;
                wakeup_req   = 1'($urandom % 2);
                level_sel    = (rail(m_lvl) == 3'b001) ? (($urandom % 2) ? 2'd3 : 2'd0) : m_lvl;
                tick("idle_active", snap(3'd0, rail(m_lvl), 1, 0, 0, 0, m_tout));
            end else begin
                shutdown_req = 1'($urandom % 2);
                wakeup_req   = 1'b0;
                level_sel    = 2'($urandom % 4);
                tick("idle_off", snap(3'd6, 3'b000, 0, 1, 1, 0, m_tout));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] L;
        int         B;
        do_reset();
        clr = 1'b0;
        do_reset();
        do_idle(3);
        do_shutdown(0, 1'b0, -1);
        do_idle(3);
        do_wakeup(2'd2, -1);
        do_shutdown(70, 1'b0, -1);
        do_idle(2);
        do_wakeup(2'd0, -1);
        do_lvlsw(2'd1);
        do_idle(2);
        do_shutdown(0, 1'b1, -1);
        do_wakeup(2'd3, -1);
        do_shutdown(0, 1'b0, 3);
        do_shutdown(2, 1'b0, -1);
        do_wakeup(2'd2, 4);
        do_idle(2);
        for (int k = 0; k < 40; k++) begin
            if (m_on) begin
                case ($urandom % 4)
                    0: begin
                        B = ($urandom % 3 == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 6));
                        do_shutdown(B, 1'($urandom % 2),
                                    ($urandom % 6 == 0) ? int'($urandom_range(0, 12)) : -1);
                    end
                    1: begin
                        do L = 2'($urandom % 4); while (rail(L) == rail(m_lvl));
                        do_lvlsw(L);
                    end
                    default: do_idle(int'($urandom_range(1, 4)));
                endcase
            end else begin
                if ($urandom % 3 != 0)
                    do_wakeup(2'($urandom % 4),
                              ($urandom % 6 == 0) ? int'($urandom_range(0, 10)) : -1);
                else
                    do_idle(int'($urandom_range(1, 4)));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
